uart_word_loader: RTL and testbench
===================================

Name: uart_word_loader

Overview:
- Upstream programming-path stage. Takes the byte stream from the UART receiver, frames it into 32-bit little-endian words, and drives the upg_* write interface of the instruction and data memories.
- Its done output feeds the memories' normal/programming mode select.
- Each session carries one header: a target byte and a 16-bit word count, followed by the payload words.

Parameters:
- ADDR_WIDTH, 14, width of upg_adr_o; maximum session length is 2**ADDR_WIDTH words.
- TIMEOUT_CYCLES, 1000000, number of idle cycles between accepted bytes, while busy, that triggers the ERROR state.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a session; honoured only in IDLE, DONE or ERROR.
- rx_valid  input  1  rx_byte is valid this cycle; single-cycle strobe; back-to-back strobes allowed.
- rx_byte  input  8  received byte.
- upg_wen_o  output  1  memory write enable; one-cycle pulse per word.
- upg_adr_o  output  ADDR_WIDTH  word address of the write.
- upg_dat_o  output  32  word data of the write.
- upg_imem_sel_o  output  1  1 = instruction memory is the target, 0 = data memory is the target.
- upg_done_o  output  1  session completed successfully; level output.
- upg_err_o  output  1  session aborted; level output.
- busy_o  output  1  high in TARGET, LEN0, LEN1 and DATA.

Behaviour:
- Clock and reset: one clock, clock; reset is synchronous and active-high.
- Reset values: state=IDLE; all outputs 0; word index, byte index and timeout counter all 0.
- Reset mid-session: discards any partial word. No write pulse is emitted after reset is asserted.

States and transitions:
- IDLE:
  - start -> TARGET.
  - rx_valid is ignored.
- TARGET:
  - rx 0x00 -> upg_imem_sel_o=0, next LEN0.
  - rx 0x01 -> upg_imem_sel_o=1, next LEN0.
  - Any other byte -> ERROR.
- LEN0: rx byte becomes count[7:0] -> LEN1.
- LEN1: rx byte becomes count[15:8], then:
  - count==0 -> DONE.
  - count > 2**ADDR_WIDTH -> ERROR.
  - Otherwise -> DATA with word index=0 and byte index=0.
- DATA:
  - Byte k (k = 0..3) of each word goes to bits [8k+7:8k].
  - Accepting byte 3 in cycle N produces, in cycle N+1: upg_wen_o=1, upg_adr_o=word index, upg_dat_o=the assembled word.
  - upg_wen_o is low in all other cycles. upg_adr_o and upg_dat_o hold their last values.
  - Word index increments after each write.
  - After the write of word count-1 -> DONE in the same cycle as that pulse, so upg_done_o rises in cycle N+2.
  - A byte arriving in cycle N+1 is accepted normally; no bytes are dropped at the full rx rate.
- DONE:
  - upg_done_o=1 and is held.
  - start -> TARGET and clears upg_done_o in the same transition.
- ERROR:
  - upg_err_o=1, upg_done_o=0.
  - start -> TARGET and clears upg_err_o.

Timeout:
- While busy, the counter clears on each rx_valid and on every state entry, and increments otherwise.
- Reaching TIMEOUT_CYCLES -> ERROR. A partial word is never written.

Simultaneous events:
- start while busy is ignored.
- start and rx_valid together in IDLE: start wins; the byte is dropped.
- reset dominates everything.

Width rules:
- count is 16 bits.
- Word index is ADDR_WIDTH+1 bits internally, so the maximum session length does not wrap. upg_adr_o carries its low ADDR_WIDTH bits.
- upg_imem_sel_o is stable from LEN0 until the next TARGET byte.

Test Plan:
- Normal data-memory session:
  - Stimulus: start, then bytes 00 02 00 | 78 56 34 12 | EF BE AD DE, spaced 1 cycle.
  - Required: two wen pulses, (adr 0, 0x12345678) then (adr 1, 0xDEADBEEF). upg_imem_sel_o=0. upg_done_o=1 two cycles after the last byte. busy_o=0.
- Back-to-back bytes at full rate, instruction-memory target:
  - Stimulus: 01 03 00 plus 12 payload bytes, with rx_valid high every cycle.
  - Required: exactly three wen pulses at adr 0,1,2, each one cycle after the word's 4th byte. upg_imem_sel_o=1. No bytes lost.
- Header errors and zero length:
  - Target byte 0x05 -> upg_err_o=1, no wen.
  - Length 0x0000 -> upg_done_o=1 immediately after LEN1, no wen.
  - Length 0x4001 with ADDR_WIDTH=14 -> ERROR.
- Timeout, with TIMEOUT_CYCLES=16:
  - Stimulus: send 00 01 00 AA BB, then silence.
  - Required: ERROR 16 cycles after BB. No wen. upg_done_o stays 0.
  - A following start plus a valid session completes normally.
- start ignored while busy:
  - Stimulus: pulse start between payload bytes.
  - Required: the session continues unchanged with correct addresses and data.
- Reset mid-word:
  - Stimulus: assert reset after 2 payload bytes.
  - Required: all outputs 0 next cycle and no wen. A new start and session writes from adr 0.

Source files
------------

// File: rtl/uart_word_loader.sv
// Frames the UART byte stream into 32-bit little-endian words and drives the
// upg_* programming write port of the instruction or data memory.
module uart_word_loader #(
   parameter int ADDR_WIDTH     = 14,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_byte,
   output logic                  upg_wen_o,
   output logic [ADDR_WIDTH-1:0] upg_adr_o,
   output logic [31:0]           upg_dat_o,
   output logic                  upg_imem_sel_o,
   output logic                  upg_done_o,
   output logic                  upg_err_o,
   output logic                  busy_o
);

   localparam int WIDX_W = ADDR_WIDTH + 1;
   localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0]      MAX_WORDS = 32'(2 ** ADDR_WIDTH);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_TARGET = 3'd1,
      S_LEN0   = 3'd2,
      S_LEN1   = 3'd3,
      S_DATA   = 3'd4,
      S_DONE   = 3'd5,
      S_ERROR  = 3'd6
   } state_t;

   state_t                  state_q;
   logic [15:0]             count_q;
   logic [WIDX_W-1:0]       widx_q;
   logic [1:0]              bidx_q;
   logic [23:0]             asm_q;
   logic [TMO_W-1:0]        tmo_q;
   logic                    wen_q;
   logic [ADDR_WIDTH-1:0]   adr_q;
   logic [31:0]             dat_q;
   logic                    imem_q;
   logic                    done_q;
   logic                    err_q;
   logic                    busy_q;

   logic [15:0]             count_d;
   logic [WIDX_W-1:0]       widx_d;
   logic [31:0]             word_d;
   logic [23:0]             asm_d;
   logic                    tmo_hit_s;
   logic                    len_zero_s;
   logic                    len_over_s;
   logic                    last_word_s;

   // Next-value helpers for the length header, byte assembly and end-of-session detection
   always_comb begin
      count_d     = {rx_byte, count_q[7:0]};
      widx_d      = widx_q + {{(WIDX_W-1){1'b0}}, 1'b1};
      word_d      = {rx_byte, asm_q};
      tmo_hit_s   = (tmo_q == TMO_LAST);
      len_zero_s  = (count_d == 16'd0);
      len_over_s  = ({16'd0, count_d} > MAX_WORDS);
      last_word_s = (32'(widx_d) == {16'd0, count_q});
      case (bidx_q)
         2'd0:    asm_d = {asm_q[23:8], rx_byte};
         2'd1:    asm_d = {asm_q[23:16], rx_byte, asm_q[7:0]};
         2'd2:    asm_d = {rx_byte, asm_q[15:0]};
         default: asm_d = asm_q;
      endcase
   end

   // Session FSM with all outputs registered
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         count_q <= 16'd0;
         widx_q  <= '0;
         bidx_q  <= 2'd0;
         asm_q   <= 24'd0;
         tmo_q   <= '0;
         wen_q   <= 1'b0;
         adr_q   <= '0;
         dat_q   <= 32'd0;
         imem_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         wen_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  state_q <= S_TARGET;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  err_q   <= 1'b0;
                  tmo_q   <= '0;
               end else if (state_q == S_DONE) begin
                  done_q <= 1'b1;
               end else begin
                  done_q <= 1'b0;
               end
            end
            S_TARGET: begin
               if (rx_valid) begin
                  tmo_q <= '0;
                  if (rx_byte == 8'h00 || rx_byte == 8'h01) begin
                     imem_q  <= rx_byte[0];
                     state_q <= S_LEN0;
                  end else begin
                     state_q <= S_ERROR;
                     err_q   <= 1'b1;
                     busy_q  <= 1'b0;
                  end
               end else if (tmo_hit_s) begin
                  state_q <= S_ERROR;
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            S_LEN0: begin
               if (rx_valid) begin
                  tmo_q         <= '0;
                  count_q[7:0]  <= rx_byte;
                  state_q       <= S_LEN1;
               end else if (tmo_hit_s) begin
                  state_q <= S_ERROR;
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            S_LEN1: begin
               if (rx_valid) begin
                  tmo_q   <= '0;
                  count_q <= count_d;
                  if (len_zero_s) begin
                     state_q <= S_DONE;
                     busy_q  <= 1'b0;
                  end else if (len_over_s) begin
                     state_q <= S_ERROR;
                     err_q   <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= S_DATA;
                     widx_q  <= '0;
                     bidx_q  <= 2'd0;
                  end
               end else if (tmo_hit_s) begin
                  state_q <= S_ERROR;
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            S_DATA: begin
               if (rx_valid) begin
                  tmo_q <= '0;
                  // Fourth byte completes the word: write it the next cycle straight from the byte lane
                  if (bidx_q == 2'd3) begin
                     wen_q  <= 1'b1;
                     adr_q  <= widx_q[ADDR_WIDTH-1:0];
                     dat_q  <= word_d;
                     widx_q <= widx_d;
                     bidx_q <= 2'd0;
                     if (last_word_s) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                     end else begin
                        state_q <= S_DATA;
                     end
                  end else begin
                     asm_q  <= asm_d;
                     bidx_q <= bidx_q + 2'd1;
                  end
               end else if (tmo_hit_s) begin
                  state_q <= S_ERROR;
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign upg_wen_o      = wen_q;
   assign upg_adr_o      = adr_q;
   assign upg_dat_o      = dat_q;
   assign upg_imem_sel_o = imem_q;
   assign upg_done_o     = done_q;
   assign upg_err_o      = err_q;
   assign busy_o         = busy_q;

endmodule

// File: tb/tb_uart_word_loader.sv
// Directed bench for uart_word_loader: expected writes go into a scoreboard
// queue that a forked monitor drains whenever upg_wen_o is seen high.
module tb_uart_word_loader;

   localparam int AW  = 14;
   localparam int TMO = 16;

   logic           clock = 1'b0;
   logic           reset;
   logic           start;
   logic           rx_valid;
   logic [7:0]     rx_byte;
   logic           upg_wen_o;
   logic [AW-1:0]  upg_adr_o;
   logic [31:0]    upg_dat_o;
   logic           upg_imem_sel_o;
   logic           upg_done_o;
   logic           upg_err_o;
   logic           busy_o;

   uart_word_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
      .clock          (clock),
      .reset          (reset),
      .start          (start),
      .rx_valid       (rx_valid),
      .rx_byte        (rx_byte),
      .upg_wen_o      (upg_wen_o),
      .upg_adr_o      (upg_adr_o),
      .upg_dat_o      (upg_dat_o),
      .upg_imem_sel_o (upg_imem_sel_o),
      .upg_done_o     (upg_done_o),
      .upg_err_o      (upg_err_o),
      .busy_o         (busy_o)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic [AW-1:0] adr;
      logic [31:0]   dat;
      logic          imem;
      int            when;
   } exp_t;

   exp_t sb_q[$];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clock);
         if (upg_wen_o !== 1'b0) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_wen: got write adr %0h dat %0h, expected no write (cycle %0d)",
                        upg_adr_o, upg_dat_o, cyc);
            end else begin
               e = sb_q.pop_front();
               chk("wen_adr",   32'(upg_adr_o), 32'(e.adr));
               chk("wen_dat",   upg_dat_o, e.dat);
               chk("wen_imem",  32'(upg_imem_sel_o), 32'(e.imem));
               chk("wen_cycle", cyc, e.when);
            end
         end
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_byte  = b;
      tick(1);
      rx_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic send_hdr(input logic [7:0] t, input logic [7:0] lo, input logic [7:0] hi, input int gap);
      drive(t);  tick(gap);
      drive(lo); tick(gap);
      drive(hi);
   endtask

   task automatic send_word(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [AW-1:0] adr, input logic [31:0] dat,
                            input logic imem, input int gap);
      drive(b0); tick(gap);
      drive(b1); tick(gap);
      drive(b2); tick(gap);
      sb_q.push_back('{adr, dat, imem, cyc + 1});
      drive(b3);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_wen"},  32'(upg_wen_o), 32'd0);
      chk({tag, "_adr"},  32'(upg_adr_o), 32'd0);
      chk({tag, "_dat"},  upg_dat_o, 32'd0);
      chk({tag, "_imem"}, 32'(upg_imem_sel_o), 32'd0);
      chk({tag, "_done"}, 32'(upg_done_o), 32'd0);
      chk({tag, "_err"},  32'(upg_err_o), 32'd0);
      chk({tag, "_busy"}, 32'(busy_o), 32'd0);
   endtask

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      rx_valid = 1'b0;
      rx_byte  = 8'h00;
      fork
         monitor();
      join_none
      tick(2);
      chk_all_zero("reset");
      reset = 1'b0;
      tick(1);

      // start together with a byte in IDLE: byte 0x01 must be dropped
      start    = 1'b1;
      rx_valid = 1'b1;
      rx_byte  = 8'h01;
      tick(1);
      start    = 1'b0;
      rx_valid = 1'b0;
      chk("idle_start_busy", 32'(busy_o), 32'd1);
      tick(1);
      send_hdr(8'h00, 8'h02, 8'h00, 1);
      tick(1);
      chk("dmem_sel", 32'(upg_imem_sel_o), 32'd0);
      send_word(8'h78, 8'h56, 8'h34, 8'h12, 14'd0, 32'h12345678, 1'b0, 1);
      tick(1);
      send_word(8'hEF, 8'hBE, 8'hAD, 8'hDE, 14'd1, 32'hDEADBEEF, 1'b0, 1);
      chk("dmem_done_lag", 32'(upg_done_o), 32'd0);
      chk("dmem_busy_end", 32'(busy_o), 32'd0);
      tick(1);
      chk("dmem_done", 32'(upg_done_o), 32'd1);
      chk("dmem_busy", 32'(busy_o), 32'd0);
      chk("dmem_sel_end", 32'(upg_imem_sel_o), 32'd0);
      chk("dmem_drained", 32'(sb_q.size()), 32'd0);

      // Full-rate instruction-memory session
      pulse_start();
      chk("restart_done_clr", 32'(upg_done_o), 32'd0);
      send_hdr(8'h01, 8'h03, 8'h00, 0);
      send_word(8'h11, 8'h22, 8'h33, 8'h44, 14'd0, 32'h44332211, 1'b1, 0);
      send_word(8'h55, 8'h66, 8'h77, 8'h88, 14'd1, 32'h88776655, 1'b1, 0);
      send_word(8'h99, 8'hAA, 8'hBB, 8'hCC, 14'd2, 32'hCCBBAA99, 1'b1, 0);
      chk("imem_sel", 32'(upg_imem_sel_o), 32'd1);
      tick(1);
      chk("imem_done", 32'(upg_done_o), 32'd1);
      chk("imem_drained", 32'(sb_q.size()), 32'd0);

      // Header errors and zero length
      pulse_start();
      drive(8'h05);
      chk("bad_target_err", 32'(upg_err_o), 32'd1);
      chk("bad_target_busy", 32'(busy_o), 32'd0);
      pulse_start();
      chk("err_cleared", 32'(upg_err_o), 32'd0);
      send_hdr(8'h00, 8'h00, 8'h00, 0);
      chk("zero_len_lag", 32'(upg_done_o), 32'd0);
      tick(1);
      chk("zero_len_done", 32'(upg_done_o), 32'd1);
      chk("zero_len_err", 32'(upg_err_o), 32'd0);
      pulse_start();
      send_hdr(8'h00, 8'h01, 8'h40, 0);
      chk("len_over_err", 32'(upg_err_o), 32'd1);
      chk("len_over_done", 32'(upg_done_o), 32'd0);

      // Timeout after a partial word, then recovery
      pulse_start();
      send_hdr(8'h00, 8'h01, 8'h00, 1);
      tick(1);
      drive(8'hAA);
      tick(1);
      drive(8'hBB);
      tick(TMO - 1);
      chk("tmo_early_err", 32'(upg_err_o), 32'd0);
      chk("tmo_early_busy", 32'(busy_o), 32'd1);
      tick(1);
      chk("tmo_err", 32'(upg_err_o), 32'd1);
      chk("tmo_done", 32'(upg_done_o), 32'd0);
      pulse_start();
      chk("tmo_err_clr", 32'(upg_err_o), 32'd0);
      send_hdr(8'h00, 8'h01, 8'h00, 0);
      send_word(8'h01, 8'h00, 8'h00, 8'h80, 14'd0, 32'h80000001, 1'b0, 0);
      tick(1);
      chk("tmo_recover_done", 32'(upg_done_o), 32'd1);

      // start pulses inside a session are ignored
      pulse_start();
      send_hdr(8'h00, 8'h02, 8'h00, 0);
      drive(8'h01);
      drive(8'h02);
      pulse_start();
      chk("start_ignored_busy", 32'(busy_o), 32'd1);
      drive(8'h03);
      sb_q.push_back('{14'd0, 32'h04030201, 1'b0, cyc + 1});
      drive(8'h04);
      pulse_start();
      send_word(8'h05, 8'h06, 8'h07, 8'h08, 14'd1, 32'h08070605, 1'b0, 0);
      tick(1);
      chk("start_ignored_done", 32'(upg_done_o), 32'd1);

      // Reset in the middle of a word
      pulse_start();
      send_hdr(8'h00, 8'h01, 8'h00, 0);
      drive(8'hAA);
      drive(8'hBB);
      reset = 1'b1;
      tick(1);
      chk_all_zero("midreset");
      reset = 1'b0;
      tick(2);
      chk("post_reset_busy", 32'(busy_o), 32'd0);
      pulse_start();
      send_hdr(8'h01, 8'h01, 8'h00, 0);
      send_word(8'h0D, 8'h0C, 8'h0B, 8'h0A, 14'd0, 32'h0A0B0C0D, 1'b1, 0);
      tick(1);
      chk("post_reset_done", 32'(upg_done_o), 32'd1);
      tick(3);
      chk("final_drained", 32'(sb_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
